// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS writeback stage: W register, result mux, HI/LO, retire counter
//
// Purpose:
//   Holds the instruction leaving the memory stage for one cycle, selects the
//   GPR write data, owns the architectural HI/LO pair written by divides and
//   counts retired instructions.
//
// Optional feature macro: HILO_BYPASS_EN
//   When defined, HiW/LoW show a divide result sitting in W in the same cycle.
//   When undefined, HiW/LoW show only the stored HI/LO registers.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   StallW, FlushW    hold / bubble control for the W register (flush wins)
//   ValidM .. DivLoM  memory-stage outputs captured into W
//   RegWriteW         qualified GPR write enable (suppressed for $0 and bubbles)
//   WriteRegW         GPR write address
//   ResultW           GPR write data
//   HiW, LoW          architectural HI/LO
//   RetireCount       instructions retired, wraps silently

module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RET_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [DATA_W-1:0] RD,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              HasDivM,
  input  logic [DATA_W-1:0] DivHiM,
  input  logic [DATA_W-1:0] DivLoM,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic [DATA_W-1:0] ResultW,
  output logic [DATA_W-1:0] HiW,
  output logic [DATA_W-1:0] LoW,
  output logic [RET_W-1:0]  RetireCount
);

  // W pipeline register fields
  logic              valid_q,     valid_d;
  logic              reg_write_q, reg_write_d;
  logic              memto_reg_q, memto_reg_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_out_q,   alu_out_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic              has_div_q,   has_div_d;
  logic [DATA_W-1:0] div_hi_q,    div_hi_d;
  logic [DATA_W-1:0] div_lo_q,    div_lo_d;

  // Architectural state
  logic [DATA_W-1:0] hi_q,      hi_d;
  logic [DATA_W-1:0] lo_q,      lo_d;
  logic [RET_W-1:0]  ret_cnt_q, ret_cnt_d;

  logic div_commit;
  logic retire;

  assign div_commit = valid_q & has_div_q;
  // The instruction in W leaves whenever W is not stalled; a flush that
  // arrives at the same edge still counts it, since it already completed.
  assign retire     = valid_q & ~StallW;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    memto_reg_d = memto_reg_q;
    read_data_d = read_data_q;
    alu_out_d   = alu_out_q;
    write_reg_d = write_reg_q;
    has_div_d   = has_div_q;
    div_hi_d    = div_hi_q;
    div_lo_d    = div_lo_q;

    if (FlushW) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      memto_reg_d = 1'b0;
      read_data_d = '0;
      alu_out_d   = '0;
      write_reg_d = '0;
      has_div_d   = 1'b0;
      div_hi_d    = '0;
      div_lo_d    = '0;
    end else if (!StallW) begin
      valid_d     = ValidM;
      reg_write_d = RegWriteM;
      memto_reg_d = MemtoRegM;
      read_data_d = RD;
      alu_out_d   = ALUOutM;
      write_reg_d = WriteRegM;
      has_div_d   = HasDivM;
      div_hi_d    = DivHiM;
      div_lo_d    = DivLoM;
    end

    // A stalled divide rewrites the same value each cycle, which is harmless.
    hi_d = div_commit ? div_hi_q : hi_q;
    lo_d = div_commit ? div_lo_q : lo_q;

    ret_cnt_d = retire ? ret_cnt_q + {{(RET_W-1){1'b0}}, 1'b1} : ret_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      read_data_q <= '0;
      alu_out_q   <= '0;
      write_reg_q <= '0;
      has_div_q   <= 1'b0;
      div_hi_q    <= '0;
      div_lo_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      ret_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      write_reg_q <= write_reg_d;
      has_div_q   <= has_div_d;
      div_hi_q    <= div_hi_d;
      div_lo_q    <= div_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign ResultW     = memto_reg_q ? read_data_q : alu_out_q;
  // Writes to $0 are dropped here so the register file needs no special case.
  assign RegWriteW   = reg_write_q & valid_q & (write_reg_q != '0);
  assign WriteRegW   = write_reg_q;
  assign RetireCount = ret_cnt_q;

`ifdef HILO_BYPASS_EN
  assign HiW = div_commit ? div_hi_q : hi_q;
  assign LoW = div_commit ? div_lo_q : lo_q;
`else
  assign HiW = hi_q;
  assign LoW = lo_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int RET_W  = 4;  // narrow counter so wrap is reachable

  logic              CLK = 1'b0;
  logic              RST;
  logic              StallW, FlushW, ValidM, RegWriteM, MemtoRegM, HasDivM;
  logic [DATA_W-1:0] RD, ALUOutM, DivHiM, DivLoM;
  logic [REG_AW-1:0] WriteRegM;
  logic              RegWriteW;
  logic [REG_AW-1:0] WriteRegW;
  logic [DATA_W-1:0] ResultW, HiW, LoW;
  logic [RET_W-1:0]  RetireCount;

  int tests = 0;
  int fails = 0;

  wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .RET_W(RET_W)) dut (
    .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .RD(RD), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
    .HasDivM(HasDivM), .DivHiM(DivHiM), .DivLoM(DivLoM),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .HiW(HiW), .LoW(LoW), .RetireCount(RetireCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_m(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr);
    ValidM = v; RegWriteM = rw; MemtoRegM = m2r;
    RD = rd; ALUOutM = alu; WriteRegM = wr;
  endtask

  initial begin
    StallW = 0; FlushW = 0; HasDivM = 0; DivHiM = 0; DivLoM = 0;
    set_m(1, 1, 0, $urandom, $urandom, 5'd3);
    HasDivM = 1; DivHiM = $urandom; DivLoM = $urandom;

    // 1: reset with random M inputs
    RST = 1;
    step();
    step();
    check("rst_regwrite", RegWriteW, 0);
    check("rst_writereg", WriteRegW, 0);
    check("rst_result", ResultW, 0);
    check("rst_hi", HiW, 0);
    check("rst_lo", LoW, 0);
    check("rst_count", RetireCount, 0);
    RST = 0;
    HasDivM = 0;

    // 2: load result from memory, then from ALU
    set_m(1, 1, 1, 32'hDEADBEEF, 32'h10, 5'd8);
    step();
    check("ld_regwrite", RegWriteW, 1);
    check("ld_writereg", WriteRegW, 8);
    check("ld_result", ResultW, 32'hDEADBEEF);
    check("ld_count", RetireCount, 0);
    MemtoRegM = 0;
    step();
    check("alu_result", ResultW, 32'h10);
    check("alu_count", RetireCount, 1);

    // 3: write to $0 suppressed but still retires
    WriteRegM = 0;
    step();
    check("r0_regwrite", RegWriteW, 0);
    check("r0_count", RetireCount, 2);

    // 4: divide commits HI/LO one cycle after entering W
    set_m(1, 0, 0, 0, 0, 5'd0);
    HasDivM = 1; DivHiM = 3; DivLoM = 7;
    step();
    check("div_count", RetireCount, 3);
`ifdef HILO_BYPASS_EN
    check("div_hi_byp", HiW, 3);
    check("div_lo_byp", LoW, 7);
`else
    check("div_hi_early", HiW, 0);
    check("div_lo_early", LoW, 0);
`endif
    HasDivM = 0;
    step();
    check("div_hi", HiW, 3);
    check("div_lo", LoW, 7);
    check("div_count2", RetireCount, 4);
    ValidM = 0; HasDivM = 1; DivHiM = 9; DivLoM = 9;
    step();
    step();
    check("bub_div_hi", HiW, 3);
    check("bub_div_lo", LoW, 7);
    check("bub_count", RetireCount, 5);
    HasDivM = 0;

    // 5: stall freezes W and the counter
    set_m(1, 1, 0, 0, 32'h55, 5'd4);
    step();
    check("st_cap_result", ResultW, 32'h55);
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1, 0, 32'h200 + i, 32'h100 + i, 5'd9);
      step();
      check("st_result", ResultW, 32'h55);
      check("st_writereg", WriteRegW, 4);
      check("st_count", RetireCount, 5);
    end
    StallW = 0;
    set_m(1, 1, 0, 0, 32'h77, 5'd5);
    step();
    check("rel_count", RetireCount, 6);
    check("rel_result", ResultW, 32'h77);
    check("rel_writereg", WriteRegW, 5);

    // 6: flush beats stall; stalled instruction does not retire
    StallW = 1; FlushW = 1;
    step();
    check("fs_regwrite", RegWriteW, 0);
    check("fs_result", ResultW, 0);
    check("fs_count", RetireCount, 6);
    StallW = 0; FlushW = 0;
    set_m(1, 1, 0, 0, 32'h1, 5'd1);
    step();                       // bubble leaves W, nothing retired
    check("fs_bub_count", RetireCount, 6);
    for (int i = 0; i < 9; i++) step();
    check("pre_wrap", RetireCount, 15);
    step();
    check("wrap", RetireCount, 0);
    // flush with valid W (no stall) still retires it
    FlushW = 1;
    step();
    check("flush_retire", RetireCount, 1);
    check("flush_regwrite", RegWriteW, 0);
    FlushW = 0;

    // reset while a divide sits in W
    HasDivM = 1; DivHiM = 32'hAA; DivLoM = 32'hBB;
    step();
    RST = 1;
    step();
    check("rst2_hi", HiW, 0);
    check("rst2_count", RetireCount, 0);
    RST = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
